// File: rtl/cdc_hs_src_if.sv
// Source-side signal bundle of the 4-phase req/ack CDC handshake.
// The master modport is the view of the cdc_hs_src controller; the slave
// modport is the view of the surrounding logic (local producer plus the
// destination domain).
`timescale 1ns/1ps

interface cdc_hs_src_if #(
    parameter int DATA_W = 8
);
    logic              src_valid_i;
    logic              src_ready_o;
    logic [DATA_W-1:0] src_data_i;
    logic              req_o;
    logic [DATA_W-1:0] data_o;
    logic              ack_i;
    logic              done_o;
    logic              timeout_o;

    modport master (
        input  src_valid_i,
        input  src_data_i,
        input  ack_i,
        output src_ready_o,
        output req_o,
        output data_o,
        output done_o,
        output timeout_o
    );

    modport slave (
        output src_valid_i,
        output src_data_i,
        output ack_i,
        input  src_ready_o,
        input  req_o,
        input  data_o,
        input  done_o,
        input  timeout_o
    );
endinterface

// File: rtl/cdc_hs_src.sv
// Source-domain controller of a 4-phase req/ack handshake carrying one
// DATA_W-bit word across a clock-domain crossing.
//  - Accepts a word with valid/ready while IDLE and holds it on data_o.
//  - Raises req_o (a flop output, so glitch-free for the destination's
//    synchronizer), waits for the synchronized ack, drops req_o, waits for
//    the synchronized ack to fall, then pulses done_o.
//  - Only the last stage of the DEPTH-flop ack synchronizer feeds the FSM.
// Optional build macro CDC_HS_TIMEOUT_EN adds a per-phase watchdog that sets
// a sticky timeout_o after TIMEOUT_CYCLES cycles in REQ or RELEASE. Without
// it, timeout_o is constant 0.
`timescale 1ns/1ps

module cdc_hs_src #(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    cdc_hs_src_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              req_q;
    logic              req_d;
    logic              done_q;
    logic              done_d;
    logic              load;
    logic [DATA_W-1:0] data_q;
    logic [DEPTH-1:0]  ack_sync;
    logic              ack_s;

    // Elaboration-time guard on the legal parameter ranges.
    if (DEPTH < 2) begin : g_depth_chk
        $error("cdc_hs_src: DEPTH must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
        $error("cdc_hs_src: TIMEOUT_CYCLES must be >= 1");
    end

    // Ack synchronizer: shift the raw asynchronous ack through DEPTH flops.
    // NOTE: sequential state is always written with non-blocking (<=) so every
    // flop samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[DEPTH-2:0], bus.ack_i};
        end
    end

    assign ack_s = ack_sync[DEPTH-1];

    // State, request, done and data registers.
    // NOTE: the held word is a plain register (not a memory), so it is reset
    // to a defined value; the destination never samples it while req_o is 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            if (load) begin
                data_q <= bus.src_data_i;
            end
        end
    end

    // Next-state and next-output decode of the 4-phase handshake.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A stale or spurious ack seen here is deliberately ignored.
                if (bus.src_valid_i) begin
                    load    = 1'b1;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.src_ready_o = (state_q == IDLE);
    assign bus.req_o       = req_q;
    assign bus.data_o      = data_q;
    assign bus.done_o      = done_q;

`ifdef CDC_HS_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] phase_cnt;
    logic             timeout_q;
    logic             phase_hold;

    // A phase continues when the FSM is waiting and stays in the same state.
    assign phase_hold = (state_q != IDLE) && (state_d == state_q);

    // Phase watchdog: clear on every state change, count while waiting,
    // saturate at TIMEOUT_CYCLES, and latch a sticky flag on reaching it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                phase_cnt <= '0;
            end else if (phase_hold && (phase_cnt != CNT_MAX)) begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            if (phase_hold && (phase_cnt == CNT_LAST)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_src.sv
// Directed testbench for cdc_hs_src (DATA_W=8, DEPTH=2, TIMEOUT_CYCLES=16).
// A destination model on an unrelated clock synchronizes req_o through two
// flops, echoes it as ack and records the word on each new request. The bench
// can switch ack_i over to a hand-driven value for the spurious-ack, reset and
// timeout scenarios. Expected timeout_o depends on CDC_HS_TIMEOUT_EN.
`timescale 1ns/1ps

module tb_cdc_hs_src;

    logic clk     = 1'b0;
    logic dst_clk = 1'b0;
    logic rstn    = 1'b0;

    int checks   = 0;
    int failures = 0;

    cdc_hs_src_if #(.DATA_W(8)) bus ();

    cdc_hs_src #(
        .DATA_W        (8),
        .DEPTH         (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

`ifdef CDC_HS_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    // Source clock: edges on integer ns. Destination clock: edges on half ns,
    // so ack_i never changes in the same timestep as a source edge.
    always #5 clk = ~clk;
    initial begin
        #0.5;
        forever #7 dst_clk = ~dst_clk;
    end

    // Destination model: 2-flop req synchronizer, ack echo, word capture.
    logic [1:0] dst_sync;
    logic       dst_ack;
    logic       dst_en     = 1'b1;
    logic       ack_manual = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge dst_clk or negedge rstn) begin
        if (!rstn) begin
            dst_sync <= 2'b00;
            dst_ack  <= 1'b0;
        end else begin
            dst_sync <= {dst_sync[0], bus.req_o};
            dst_ack  <= dst_sync[1];
            if (dst_sync[1] && !dst_ack) rx_q.push_back(bus.data_o);
        end
    end

    assign bus.ack_i = dst_en ? dst_ack : ack_manual;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rstn = 1'b0;
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_o !== 1'b0) begin
            failures++; $display("FAIL reset_hold_req: got %b want 0", bus.req_o);
        end
        rstn = 1'b1;
        checks++;
        if (bus.src_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b want 1", bus.src_ready_o);
        end
        checks++;
        if (bus.req_o !== 1'b0) begin
            failures++; $display("FAIL reset_req: got %b want 0", bus.req_o);
        end
        checks++;
        if (bus.data_o !== 8'h00) begin
            failures++; $display("FAIL reset_data: got %h want 00", bus.data_o);
        end
        checks++;
        if (bus.done_o !== 1'b0) begin
            failures++; $display("FAIL reset_done: got %b want 0", bus.done_o);
        end
        checks++;
        if (bus.timeout_o !== 1'b0) begin
            failures++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_o);
        end
    endtask

    task automatic test_single();
        int n;
        int lat;
        int held_bad = 0;
        rx_q.delete();
        @(negedge clk);
        bus.src_valid_i = 1'b1;
        bus.src_data_i  = 8'hA5;
        @(negedge clk);
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 8'hFF;
        checks++;
        if (bus.req_o !== 1'b1 || bus.data_o !== 8'hA5) begin
            failures++;
            $display("FAIL single_req_after_accept: req=%b data=%h want req=1 data=a5", bus.req_o, bus.data_o);
        end
        checks++;
        if (bus.src_ready_o !== 1'b0) begin
            failures++; $display("FAIL single_ready_busy: got %b want 0", bus.src_ready_o);
        end
        n = 0;
        while (bus.ack_i !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
            if (bus.data_o !== 8'hA5) held_bad++;
        end
        checks++;
        if (n >= 100) begin
            failures++; $display("FAIL single_ack_rise_wait: waited %0d cycles want < 100", n);
        end
        lat = 0;
        while (bus.req_o !== 1'b0 && lat < 20) begin
            @(negedge clk); lat++;
            if (bus.data_o !== 8'hA5) held_bad++;
        end
        checks++;
        if (lat < 2 || lat > 3) begin
            failures++; $display("FAIL single_req_fall_latency: got %0d want 2..3", lat);
        end
        n = 0;
        while (bus.ack_i !== 1'b0 && n < 100) begin
            @(negedge clk); n++;
            if (bus.data_o !== 8'hA5) held_bad++;
        end
        checks++;
        if (n >= 100) begin
            failures++; $display("FAIL single_ack_fall_wait: waited %0d cycles want < 100", n);
        end
        lat = 0;
        while (bus.done_o !== 1'b1 && lat < 20) begin
            @(negedge clk); lat++;
            if (bus.data_o !== 8'hA5) held_bad++;
        end
        checks++;
        if (lat < 2 || lat > 3) begin
            failures++; $display("FAIL single_done_latency: got %0d want 2..3", lat);
        end
        checks++;
        if (bus.src_ready_o !== 1'b1) begin
            failures++; $display("FAIL single_ready_in_done: got %b want 1", bus.src_ready_o);
        end
        checks++;
        if (held_bad != 0) begin
            failures++; $display("FAIL single_data_held: %0d samples differ from a5, want 0", held_bad);
        end
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b0) begin
            failures++; $display("FAIL single_done_one_cycle: got %b want 0", bus.done_o);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            failures++; $display("FAIL single_rx: got %0d words (first %h) want 1 word a5", rx_q.size(),
                                 (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int   idx = 0;
        int   dones = 0;
        int   cyc = 0;
        int   stable_bad = 0;
        logic accepting;
        logic active;
        logic prev_active = 1'b0;
        logic [7:0] prev_data = 8'h00;
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        rx_q.delete();
        @(negedge clk);
        bus.src_valid_i = 1'b1;
        bus.src_data_i  = words[0];
        while ((idx < 3 || dones < 3) && cyc < 500) begin
            accepting = bus.src_ready_o && bus.src_valid_i;
            @(negedge clk); cyc++;
            if (bus.done_o === 1'b1) dones++;
            active = bus.req_o || bus.ack_i;
            if (prev_active && active && bus.data_o !== prev_data) stable_bad++;
            prev_active = active;
            prev_data   = bus.data_o;
            if (accepting) begin
                checks++;
                if (bus.req_o !== 1'b1 || bus.data_o !== words[idx]) begin
                    failures++;
                    $display("FAIL b2b_accept_%0d: req=%b data=%h want req=1 data=%h", idx, bus.req_o, bus.data_o, words[idx]);
                end
                idx++;
                if (idx < 3) bus.src_data_i = words[idx];
                else         bus.src_valid_i = 1'b0;
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) dones++;
        end
        checks++;
        if (cyc >= 500) begin
            failures++; $display("FAIL b2b_timeout: ran %0d cycles want < 500", cyc);
        end
        checks++;
        if (dones != 3) begin
            failures++; $display("FAIL b2b_done_count: got %0d want 3", dones);
        end
        checks++;
        if (rx_q.size() != 3) begin
            failures++; $display("FAIL b2b_rx_count: got %0d want 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== words[i]) begin
                    failures++; $display("FAIL b2b_rx_order_%0d: got %h want %h", i, rx_q[i], words[i]);
                end
            end
        end
        checks++;
        if (stable_bad != 0) begin
            failures++; $display("FAIL b2b_data_stable: %0d changes while busy want 0", stable_bad);
        end
    endtask

    task automatic test_spurious_ack();
        dst_en     = 1'b0;
        ack_manual = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_o !== 1'b0 || bus.src_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
                failures++;
                $display("FAIL spurious_ack_high_%0d: req=%b ready=%b done=%b want 0 1 0", i, bus.req_o, bus.src_ready_o, bus.done_o);
            end
        end
        ack_manual = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_o !== 1'b0 || bus.src_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
                failures++;
                $display("FAIL spurious_ack_low_%0d: req=%b ready=%b done=%b want 0 1 0", i, bus.req_o, bus.src_ready_o, bus.done_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        dst_en     = 1'b0;
        ack_manual = 1'b0;
        @(negedge clk);
        bus.src_valid_i = 1'b1;
        bus.src_data_i  = 8'h3C;
        @(negedge clk);
        bus.src_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_o !== 1'b1 || bus.data_o !== 8'h3C || bus.src_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_req: req=%b data=%h ready=%b want 1 3c 0", bus.req_o, bus.data_o, bus.src_ready_o);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.req_o !== 1'b0 || bus.data_o !== 8'h00 || bus.src_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_reset: req=%b data=%h ready=%b done=%b want 0 00 1 0",
                     bus.req_o, bus.data_o, bus.src_ready_o, bus.done_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.src_ready_o !== 1'b1 || bus.req_o !== 1'b0) begin
            failures++; $display("FAIL mid_after_release: ready=%b req=%b want 1 0", bus.src_ready_o, bus.req_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        dst_en     = 1'b0;
        ack_manual = 1'b0;
        @(negedge clk);
        bus.src_valid_i = 1'b1;
        bus.src_data_i  = 8'h5A;
        @(negedge clk);
        bus.src_valid_i = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (bus.timeout_o !== 1'b0) begin
            failures++; $display("FAIL timeout_early: got %b want 0 after 15 REQ cycles", bus.timeout_o);
        end
        @(negedge clk);
        checks++;
        if (bus.timeout_o !== TO_EXP) begin
            failures++; $display("FAIL timeout_at_16: got %b want %b", bus.timeout_o, TO_EXP);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (bus.timeout_o !== TO_EXP || bus.req_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky_waiting: timeout=%b req=%b want %b 1", bus.timeout_o, bus.req_o, TO_EXP);
        end
        ack_manual = 1'b1;
        n = 0;
        while (bus.req_o !== 1'b0 && n < 20) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 20) begin
            failures++; $display("FAIL timeout_req_fall: waited %0d cycles want < 20", n);
        end
        ack_manual = 1'b0;
        n = 0;
        while (bus.done_o !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 20) begin
            failures++; $display("FAIL timeout_done: waited %0d cycles want < 20", n);
        end
        checks++;
        if (bus.timeout_o !== TO_EXP || bus.data_o !== 8'h5A) begin
            failures++;
            $display("FAIL timeout_after_done: timeout=%b data=%h want %b 5a", bus.timeout_o, bus.data_o, TO_EXP);
        end
    endtask

    initial begin
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
